// File: rtl/axi_sram_responder.sv
// AXI4-subset INCR burst responder over a 32-bit word SRAM, one transaction at a time.
// Define AXI_SLV_BACKPRESSURE_EN to add LFSR-driven stalls on AR, AW, W and R issue.
module axi_sram_responder #(
    parameter int MEM_AW    = 12,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int         DEPTH       = 1 << MEM_AW;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, WR_DATA, WR_RESP} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];

    // Oversized beats (size > 2) are served as full words.
    function automatic logic [31:0] beat_step(input logic [2:0] size);
        return (size > 3'd2) ? 32'd4 : (32'd1 << size);
    endfunction

    logic go;
`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign go = lfsr[0];
`else
    assign go = 1'b1;
`endif

    logic        rr_pri;
    logic        both;
    logic        ar_hs, aw_hs, w_hs;

    logic [31:0] rd_addr;
    logic [7:0]  rd_cnt, rd_len;
    logic [2:0]  rd_size;

    logic [31:0] wr_addr;
    logic [7:0]  wr_cnt, wr_len;
    logic [2:0]  wr_size;
    logic        wr_err;
    logic        wr_last_beat;
    logic        wlast_bad;

    // Contention only when both address channels are valid; rr_pri names the winner.
    assign both    = arvalid & awvalid;
    assign arready = rst & go & (state == IDLE) & ~(both & rr_pri);
    assign awready = rst & go & (state == IDLE) & ~(both & ~rr_pri);
    assign wready  = go & (state == WR_DATA);

    assign ar_hs = arvalid & arready;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    assign wr_last_beat = (wr_cnt == wr_len);
    assign wlast_bad    = (wlast != wr_last_beat);

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[wr_addr[MEM_AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rr_pri  <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= 32'd0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            rd_addr <= 32'd0;
            rd_cnt  <= 8'd0;
            rd_len  <= 8'd0;
            rd_size <= 3'd0;
            wr_addr <= 32'd0;
            wr_cnt  <= 8'd0;
            wr_len  <= 8'd0;
            wr_size <= 3'd0;
            wr_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (both && (ar_hs || aw_hs)) rr_pri <= ~rr_pri;
                    if (ar_hs) begin
                        // Beat 0 is fetched on the handshake so rvalid rises next cycle.
                        rdata   <= mem[araddr[MEM_AW+1:2]];
                        rlast   <= (arlen == 8'd0);
                        rvalid  <= 1'b1;
                        rd_addr <= araddr + beat_step(arsize);
                        rd_cnt  <= 8'd1;
                        rd_len  <= arlen;
                        rd_size <= arsize;
                        state   <= RD;
                    end else if (aw_hs) begin
                        wr_addr <= awaddr;
                        wr_cnt  <= 8'd0;
                        wr_len  <= awlen;
                        wr_size <= awsize;
                        wr_err  <= 1'b0;
                        state   <= WR_DATA;
                    end
                end
                RD: begin
                    // rd_addr/rd_cnt always describe the next beat to present.
                    if (rvalid && rready && rlast) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        state  <= IDLE;
                    end else if (go && (!rvalid || rready)) begin
                        rdata   <= mem[rd_addr[MEM_AW+1:2]];
                        rlast   <= (rd_cnt == rd_len);
                        rvalid  <= 1'b1;
                        rd_addr <= rd_addr + beat_step(rd_size);
                        rd_cnt  <= rd_cnt + 8'd1;
                    end else if (rready) begin
                        rvalid <= 1'b0;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        wr_addr <= wr_addr + beat_step(wr_size);
                        wr_cnt  <= wr_cnt + 8'd1;
                        if (wr_last_beat) begin
                            bvalid <= 1'b1;
                            bresp  <= (wr_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                            state  <= WR_RESP;
                        end else begin
                            wr_err <= wr_err | wlast_bad;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed plus randomized bench for axi_sram_responder against a word-array model
// that derives beat addresses arithmetically from start address, size and beat number.
module tb_axi_sram_responder;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast, rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    always #5 clk = ~clk;

    axi_sram_responder #(.MEM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] baddr(input logic [31:0] a, input int size, input int i);
        int sz;
        sz = (size > 2) ? 2 : size;
        return a + 32'(i) * (32'd1 << sz);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        w = widx(a);
        for (int b = 0; b < 4; b++) if (s[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
    endtask

    // All channel tasks start and end just after a rising edge.
    task automatic aw_send(input logic [31:0] a, input int len, input int size);
        int n;
        n = 0;
        awaddr = a; awlen = 8'(len); awsize = 3'(size); awvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_handshake", 32'(awready), 32'd1);
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n;
        n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        @(negedge clk);
        while (!wready && n < 50) begin @(negedge clk); n++; end
        chk("w_handshake", 32'(wready), 32'd1);
        @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(input logic [1:0] exp);
        int n;
        n = 0;
        bready = 1'b1;
        @(negedge clk);
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bresp", 32'(bresp), 32'(exp));
        @(posedge clk); #1 bready = 1'b0;
    endtask

    task automatic wr_burst(input logic [31:0] a, input int len, input int size,
                            input logic [31:0] d[$], input logic [3:0] s[$], input int early);
        aw_send(a, len, size);
        for (int i = 0; i <= len; i++) begin
            w_beat(d[i], s[i], (i == len) || (i == early));
            mdl_write(baddr(a, size, i), d[i], s[i]);
        end
        chk("bvalid_after_last_w", 32'(bvalid), 32'd1);
        b_recv((early >= 0 && early != len) ? 2'b10 : 2'b00);
    endtask

    task automatic rd_burst(input logic [31:0] a, input int len, input int size,
                            input int stall_beat, input int stall_n);
        int          n;
        logic [31:0] exp;
        n = 0;
        araddr = a; arlen = 8'(len); arsize = 3'(size); arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_handshake", 32'(arready), 32'd1);
        @(posedge clk); #1 arvalid = 1'b0;
        chk("rvalid_after_ar", 32'(rvalid), 32'd1);
        for (int i = 0; i <= len; i++) begin
            exp = mdl[widx(baddr(a, size, i))];
            if (i == stall_beat) begin
                rready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge clk);
                    chk("rdata_held", rdata, exp);
                    chk("rvalid_held", 32'(rvalid), 32'd1);
                    @(posedge clk); #1;
                end
            end
            rready = 1'b1;
            n = 0;
            @(negedge clk);
            while (!rvalid && n < 50) begin @(negedge clk); n++; end
            chk("rvalid_beat", 32'(rvalid), 32'd1);
            chk("rdata_beat", rdata, exp);
            chk("rlast_beat", 32'(rlast), 32'(i == len));
            @(posedge clk); #1;
        end
        rready = 1'b0;
        chk("rvalid_done", 32'(rvalid), 32'd0);
    endtask

    initial begin
        logic [31:0] d[$];
        logic [3:0]  s[$];
        logic [31:0] a, base;
        int          len, sz, szc, span, nw, early, sb, sn;

        // Reset state
        @(negedge clk);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // W offered before any AW must not be accepted
        wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
        repeat (2) begin
            @(negedge clk);
            chk("w_before_aw", 32'(wready), 32'd0);
        end
        @(posedge clk); #1 wvalid = 1'b0;

        // Single write / read
        d = '{32'hDEADBEEF}; s = '{4'hF};
        wr_burst(32'h100, 0, 2, d, s, -1);
        rd_burst(32'h100, 0, 2, -1, 0);

        // Line refill with R back-pressure on beat 4
        d = {}; s = {};
        for (int i = 0; i < 8; i++) begin d.push_back(32'(i)); s.push_back(4'hF); end
        wr_burst(32'h1FE0, 7, 2, d, s, -1);
        rd_burst(32'h1FE0, 7, 2, 4, 3);

        // Byte-lane write into a preset word
        d = '{32'h11223344}; s = '{4'hF};
        wr_burst(32'h40, 0, 2, d, s, -1);
        d = '{32'h00AA0000}; s = '{4'b0100};
        wr_burst(32'h42, 0, 0, d, s, -1);
        rd_burst(32'h40, 0, 2, -1, 0);

        // Index alias above the array and 32-bit address wrap
        d = '{32'hCAFEF00D}; s = '{4'hF};
        wr_burst(32'h4000, 0, 2, d, s, -1);
        rd_burst(32'h0000, 0, 2, -1, 0);
        d = '{32'hA5A5A5A5, 32'h5A5A5A5A}; s = '{4'hF, 4'hF};
        wr_burst(32'hFFFFFFFC, 1, 2, d, s, -1);
        rd_burst(32'hFFFFFFFC, 1, 2, -1, 0);
        rd_burst(32'h0000, 0, 2, 0, 2);

        // Oversized beat is treated as a word; zero-strobe beat is a no-op
        d = '{32'h01010101, 32'h02020202}; s = '{4'hF, 4'hF};
        wr_burst(32'h500, 1, 3, d, s, -1);
        rd_burst(32'h500, 1, 2, -1, 0);
        d = '{32'h0, 32'h77777777, 32'h0}; s = '{4'hF, 4'hF, 4'hF};
        wr_burst(32'h600, 2, 2, d, s, -1);
        d = '{32'h11111111, 32'hFFFFFFFF, 32'h33333333}; s = '{4'hF, 4'h0, 4'hF};
        wr_burst(32'h600, 2, 2, d, s, -1);
        rd_burst(32'h600, 2, 3, -1, 0);

        // Reset in the middle of a read burst
        araddr = 32'h1FE0; arlen = 8'd7; arsize = 3'd2; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        chk("mid_ar_ready", 32'(arready), 32'd1);
        @(posedge clk); #1 arvalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rlast", 32'(rlast), 32'd0);
        chk("midrst_arready", 32'(arready), 32'd0);
        chk("midrst_awready", 32'(awready), 32'd0);
        chk("midrst_wready", 32'(wready), 32'd0);
        chk("midrst_bvalid", 32'(bvalid), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1; rready = 1'b0;
        @(negedge clk);
        chk("postrst_arready", 32'(arready), 32'd1);
        chk("postrst_awready", 32'(awready), 32'd1);
        chk("postrst_rvalid", 32'(rvalid), 32'd0);

        // Contention from reset: read wins first, then the write
        @(posedge clk); #1;
        araddr = 32'h100; arlen = 8'd0; arsize = 3'd2; arvalid = 1'b1;
        awaddr = 32'h300; awlen = 8'd3; awsize = 3'd2; awvalid = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        chk("cont1_arready", 32'(arready), 32'd1);
        chk("cont1_awready", 32'(awready), 32'd0);
        @(posedge clk); #1;
        chk("cont1_rvalid", 32'(rvalid), 32'd1);
        chk("cont1_rdata", rdata, mdl[widx(32'h100)]);
        chk("cont1_rlast", 32'(rlast), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cont2_arready", 32'(arready), 32'd0);
        chk("cont2_awready", 32'(awready), 32'd1);
        @(posedge clk); #1 awvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_beat(32'hB0 + 32'(i), 4'hF, (i >= 2));
            mdl_write(baddr(32'h300, 2, i), 32'hB0 + 32'(i), 4'hF);
        end
        chk("cont_bvalid", 32'(bvalid), 32'd1);
        b_recv(2'b10);
        @(negedge clk);
        chk("cont3_arready", 32'(arready), 32'd1);
        @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        chk("cont3_rvalid", 32'(rvalid), 32'd1);
        chk("cont3_rdata", rdata, mdl[widx(32'h100)]);
        @(posedge clk); #1 rready = 1'b0;
        rd_burst(32'h300, 3, 2, 1, 1);

        // Randomized bursts: seed the words touched, then a random-strobe burst, then reads
        for (int t = 0; t < 16; t++) begin
            a     = $urandom;
            len   = $urandom_range(0, 7);
            sz    = $urandom_range(0, 3);
            szc   = (sz > 2) ? 2 : sz;
            span  = (len + 1) << szc;
            nw    = (int'(a & 32'd3) + span + 3) / 4;
            base  = a & ~32'd3;
            d = {}; s = {};
            for (int i = 0; i < nw; i++) begin d.push_back($urandom); s.push_back(4'hF); end
            wr_burst(base, nw - 1, 2, d, s, -1);
            d = {}; s = {};
            for (int i = 0; i <= len; i++) begin d.push_back($urandom); s.push_back(4'($urandom)); end
            early = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
            wr_burst(a, len, sz, d, s, early);
            sb = $urandom_range(0, len);
            sn = $urandom_range(0, 2);
            rd_burst(a, len, sz, sb, sn);
            rd_burst(base, nw - 1, 2, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
